// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-ported, multi-cycle 64-bit data memory between fetch (F) and memory stage (M).
// Define DMEM_ARB_STARVE_GUARD_EN to build the F starvation guard (F forced after MAX_STREAK contested M grants).
module dmem_port_arbiter #(
   parameter int MEM_WORDS  = 1024,
   parameter int MEM_LAT    = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   output logic        f_done,
   output logic [63:0] f_rdata,
   output logic        f_err,
   output logic        m_done,
   output logic [63:0] m_rdata,
   output logic        m_err,
   output logic        f_stall,
   output logic        m_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [1:0] S_ERR    = 2'd3;

   localparam int              CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
   localparam logic [63:0]      ADDR_LIMIT = 64'(MEM_WORDS);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             owner_m;
   logic             lat_we;
   logic             grant_m;
   logic             grant_f;
   logic             f_forced;
   logic [63:0]      sel_addr;
   logic             sel_oor;

   // Handshake: a requester holds req and its fields until its one-cycle done pulse; req seen high
   // again in IDLE is a new transaction. stall is simply "req pending and not completing this cycle".
   assign f_stall = f_req & ~f_done;
   assign m_stall = m_req & ~m_done;
   assign busy    = (state != S_IDLE);
   assign mem_en  = (state == S_ACCESS);
   assign mem_we  = mem_en & lat_we;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int STREAK_W = $clog2(MAX_STREAK + 1);
   logic [STREAK_W-1:0] streak;

   assign f_forced = (streak == STREAK_W'(MAX_STREAK));

   // Counts M grants that F lost; any F grant resets the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (state == S_IDLE) begin
         if (grant_f)
            streak <= '0;
         else if (grant_m && f_req)
            streak <= streak + 1'b1;
      end
   end
`else
   // Strict M priority; MAX_STREAK only matters to the guard build.
   assign f_forced = (MAX_STREAK < 0);
`endif

   assign grant_m  = m_req & ~(f_req & f_forced);
   assign grant_f  = f_req & ~grant_m;
   assign sel_addr = grant_m ? m_addr : f_addr;
   assign sel_oor  = (sel_addr >= ADDR_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         owner_m   <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_done    <= 1'b0;
         f_err     <= 1'b0;
         f_rdata   <= '0;
         m_done    <= 1'b0;
         m_err     <= 1'b0;
         m_rdata   <= '0;
      end else begin
         f_done <= 1'b0;
         f_err  <= 1'b0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_m || grant_f) begin
                  owner_m <= grant_m;
                  lat_we  <= grant_m & m_we;
                  if (sel_oor) begin
                     // Error response is issued directly; the memory is never touched.
                     state <= S_ERR;
                     if (grant_m) begin
                        m_done  <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                     end else begin
                        f_done  <= 1'b1;
                        f_err   <= 1'b1;
                        f_rdata <= '0;
                     end
                  end else begin
                     state    <= S_ACCESS;
                     cnt      <= CNT_INIT;
                     mem_addr <= sel_addr;
                     if (grant_m)
                        mem_wdata <= m_wdata;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt == '0) begin
                  state <= S_RESP;
                  if (owner_m) begin
                     m_done  <= 1'b1;
                     m_rdata <= lat_we ? mem_wdata : mem_rdata;
                  end else begin
                     f_done  <= 1'b1;
                     f_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a transaction-level model.
// Build with +define+DMEM_ARB_STARVE_GUARD_EN to check the guarded arbitration instead of strict M priority.
module tb_dmem_port_arbiter;

   localparam int MEM_WORDS  = 1024;
   localparam int MEM_LAT    = 2;
   localparam int MAX_STREAK = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req, m_req, m_we;
   logic [63:0] f_addr, m_addr, m_wdata;
   logic        f_done, f_err, m_done, m_err, f_stall, m_stall;
   logic [63:0] f_rdata, m_rdata;
   logic        mem_en, mem_we, busy;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   logic        mem_init;
   logic [63:0] mem_array [MEM_WORDS];
   logic [63:0] ref_mem   [MEM_WORDS];

   int n_tests = 0;
   int n_fail  = 0;

   dmem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
      .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
      .f_stall(f_stall), .m_stall(m_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input int i);
      if (i == 5) return 64'h55;
      return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h9E37_79B9};
   endfunction

   // Memory array seen by the arbiter: combinational read, write on each enabled write cycle.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_array[i] <= pat(i);
      end else if (mem_en && mem_we && mem_addr < 64'(MEM_WORDS)) begin
         mem_array[mem_addr[9:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_array[mem_addr[9:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input logic [63:0] a);
      return (a >= 64'(MEM_WORDS)) ? 1 : MEM_LAT + 1;
   endfunction

   function automatic logic [63:0] rand_addr();
      int k;
      k = $urandom_range(0, 9);
      case (k)
         0:       return 64'(MEM_WORDS) + 64'($urandom_range(0, 3));
         1:       return {32'h1, 32'h5};
         2:       return 64'(MEM_WORDS - 1);
         default: return 64'($urandom_range(0, 15));
      endcase
   endfunction

   // Round-level model state
   logic        f_on, m_on, mwe, f_gerr, m_gerr;
   logic [63:0] fa, ma, mwd, f_exp_d, m_exp_d, f_got, m_got;
   logic        f_exp_e, m_exp_e;
   int          f_exp_cyc, m_exp_cyc, f_cyc, m_cyc, f_cnt, m_cnt, f_at, any_done;

   initial begin
      rst_n = 1'b0; mem_init = 1'b1;
      f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);

      // Reset state
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_done", {62'd0, f_done, m_done}, 64'd0);
      chk("rst_err", {62'd0, f_err, m_err}, 64'd0);
      chk("rst_rdata", f_rdata | m_rdata, 64'd0);
      chk("rst_stall", {62'd0, f_stall, m_stall}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1; mem_init = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_outs", {60'd0, f_done, m_done, mem_en, f_err}, 64'd0);

      // F read of word 5
      @(posedge clk); #1; f_req = 1'b1; f_addr = 64'd5;
      @(negedge clk);
      chk("fr_t0_stall", 64'(f_stall), 64'd1);
      chk("fr_t0_mem_en", 64'(mem_en), 64'd0);
      @(negedge clk);
      chk("fr_t1_mem_en", 64'(mem_en), 64'd1);
      chk("fr_t1_mem_addr", mem_addr, 64'd5);
      chk("fr_t1_mem_we", 64'(mem_we), 64'd0);
      chk("fr_t1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("fr_t2_mem_en", 64'(mem_en), 64'd1);
      chk("fr_t2_stall", 64'(f_stall), 64'd1);
      chk("fr_t2_done", 64'(f_done), 64'd0);
      @(negedge clk);
      chk("fr_t3_done", 64'(f_done), 64'd1);
      chk("fr_t3_rdata", f_rdata, 64'h55);
      chk("fr_t3_err", 64'(f_err), 64'd0);
      chk("fr_t3_stall", 64'(f_stall), 64'd0);
      chk("fr_t3_mem_en", 64'(mem_en), 64'd0);
      @(posedge clk); #1; f_req = 1'b0;

      // M write 0xDEAD to word 8, then read it back
      @(posedge clk); #1; m_req = 1'b1; m_we = 1'b1; m_addr = 64'd8; m_wdata = 64'hDEAD;
      ref_mem[8] = 64'hDEAD;
      @(negedge clk);
      chk("mw_t0_stall", 64'(m_stall), 64'd1);
      @(negedge clk);
      chk("mw_t1_mem_we", 64'(mem_we), 64'd1);
      chk("mw_t1_mem_addr", mem_addr, 64'd8);
      chk("mw_t1_mem_wdata", mem_wdata, 64'hDEAD);
      repeat (2) @(negedge clk);
      chk("mw_t3_done", 64'(m_done), 64'd1);
      chk("mw_t3_rdata", m_rdata, 64'hDEAD);
      @(posedge clk); #1; m_req = 1'b0;
      @(posedge clk); #1; m_req = 1'b1; m_we = 1'b0; m_wdata = 64'h1234;
      repeat (2) @(negedge clk);
      chk("mr_t1_mem_we", 64'(mem_we), 64'd0);
      repeat (2) @(negedge clk);
      chk("mr_t3_done", 64'(m_done), 64'd1);
      chk("mr_t3_rdata", m_rdata, 64'hDEAD);
      @(posedge clk); #1; m_req = 1'b0;

      // Simultaneous requests: M first, F re-arbitrated in the following IDLE
      @(posedge clk); #1; f_req = 1'b1; f_addr = 64'd3; m_req = 1'b1; m_addr = 64'd4;
      repeat (4) @(negedge clk);
      chk("sim_t3_m_done", 64'(m_done), 64'd1);
      chk("sim_t3_m_rdata", m_rdata, ref_mem[4]);
      chk("sim_t3_f_done", 64'(f_done), 64'd0);
      chk("sim_t3_f_stall", 64'(f_stall), 64'd1);
      @(posedge clk); #1; m_req = 1'b0;
      @(negedge clk);
      repeat (2) @(negedge clk);
      chk("sim_t6_f_done", 64'(f_done), 64'd0);
      @(negedge clk);
      chk("sim_t7_f_done", 64'(f_done), 64'd1);
      chk("sim_t7_f_rdata", f_rdata, ref_mem[3]);
      @(posedge clk); #1; f_req = 1'b0;

      // Out-of-range addresses
      @(posedge clk); #1; m_req = 1'b1; m_addr = 64'(MEM_WORDS);
      @(negedge clk);
      chk("oor_m_t0_mem_en", 64'(mem_en), 64'd0);
      @(negedge clk);
      chk("oor_m_done", 64'(m_done), 64'd1);
      chk("oor_m_err", 64'(m_err), 64'd1);
      chk("oor_m_rdata", m_rdata, 64'd0);
      chk("oor_m_mem_en", 64'(mem_en), 64'd0);
      @(posedge clk); #1; m_req = 1'b0;
      @(posedge clk); #1; f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(negedge clk);
      chk("oor_f_done", 64'(f_done), 64'd1);
      chk("oor_f_err", 64'(f_err), 64'd1);
      chk("oor_f_rdata", f_rdata, 64'd0);
      @(posedge clk); #1; f_req = 1'b0;

      // Reset during ACCESS aborts without a done pulse
      @(posedge clk); #1; f_req = 1'b1; f_addr = 64'd6;
      repeat (2) @(negedge clk);
      chk("mid_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0; #1;
      chk("mid_busy_after", 64'(busy), 64'd0);
      chk("mid_mem_en_after", 64'(mem_en), 64'd0);
      f_req = 1'b0;
      any_done = 0;
      repeat (2) begin @(negedge clk); any_done += int'(f_done); end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); any_done += int'(f_done | m_done); end
      chk("mid_no_done", 64'(any_done), 64'd0);

      // Both requests held continuously
      @(posedge clk); #1; f_req = 1'b1; f_addr = 64'd11; m_req = 1'b1; m_we = 1'b0; m_addr = 64'd10;
      m_cnt = 0; f_cnt = 0; f_cyc = -1; f_at = -1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_done) m_cnt++;
         if (f_done && f_cyc < 0) begin f_cyc = c; f_at = m_cnt; end
         @(posedge clk); #1;
         if (f_cyc >= 0) break;
      end
      f_req = 1'b0; m_req = 1'b0;
      chk("guard_m_grants_before_f", 64'(f_at), 64'(MAX_STREAK));
      chk("guard_f_done_cycle", 64'(f_cyc), 64'(MAX_STREAK * (MEM_LAT + 2) + MEM_LAT + 1));
`else
      for (int c = 0; c < 7 * (MEM_LAT + 2); c++) begin
         @(negedge clk);
         if (m_done) m_cnt++;
         if (f_done) f_cnt++;
         @(posedge clk); #1;
      end
      f_req = 1'b0; m_req = 1'b0;
      chk("prio_m_grants", 64'(m_cnt), 64'd7);
      chk("prio_f_starved", 64'(f_cnt), 64'd0);
`endif
      @(posedge clk); #1;

      // Randomized rounds against the transaction model
      for (int r = 0; r < 40; r++) begin
         f_on = 1'($urandom_range(0, 1));
         m_on = 1'($urandom_range(0, 1));
         if (!f_on && !m_on) m_on = 1'b1;
         fa = rand_addr(); ma = rand_addr();
         mwe = 1'($urandom_range(0, 1)); mwd = {$urandom, $urandom};
         m_exp_cyc = lat_of(ma); m_exp_d = '0; m_exp_e = 1'b0;
         if (ma >= 64'(MEM_WORDS)) m_exp_e = 1'b1;
         else if (mwe) begin m_exp_d = mwd; if (m_on) ref_mem[ma[9:0]] = mwd; end
         else m_exp_d = ref_mem[ma[9:0]];
         f_exp_cyc = (m_on ? m_exp_cyc + 1 : 0) + lat_of(fa);
         f_exp_e = (fa >= 64'(MEM_WORDS));
         f_exp_d = f_exp_e ? 64'd0 : ref_mem[fa[9:0]];

         @(posedge clk); #1;
         f_req = f_on; f_addr = fa; m_req = m_on; m_we = mwe; m_addr = ma; m_wdata = mwd;
         f_cnt = 0; m_cnt = 0; f_cyc = -1; m_cyc = -1;
         f_got = '0; m_got = '0; f_gerr = 1'b0; m_gerr = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f_done) begin f_cnt++; f_cyc = c; f_got = f_rdata; f_gerr = f_err; end
            if (m_done) begin m_cnt++; m_cyc = c; m_got = m_rdata; m_gerr = m_err; end
            @(posedge clk); #1;
            if (f_cyc == c) f_req = 1'b0;
            if (m_cyc == c) m_req = 1'b0;
            if ((!f_on || f_cyc >= 0) && (!m_on || m_cyc >= 0)) break;
         end
         f_req = 1'b0; m_req = 1'b0;
         chk($sformatf("rnd%0d_f_count", r), 64'(f_cnt), 64'(f_on));
         chk($sformatf("rnd%0d_m_count", r), 64'(m_cnt), 64'(m_on));
         if (m_on) begin
            chk($sformatf("rnd%0d_m_cycle", r), 64'(m_cyc), 64'(m_exp_cyc));
            chk($sformatf("rnd%0d_m_rdata", r), m_got, m_exp_d);
            chk($sformatf("rnd%0d_m_err", r), 64'(m_gerr), 64'(m_exp_e));
         end
         if (f_on) begin
            chk($sformatf("rnd%0d_f_cycle", r), 64'(f_cyc), 64'(f_exp_cyc));
            chk($sformatf("rnd%0d_f_rdata", r), f_got, f_exp_d);
            chk($sformatf("rnd%0d_f_err", r), 64'(f_gerr), 64'(f_exp_e));
         end
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
